// File: rtl/connect_board_engine.sv
// Connect-N board engine: gravity drops, alternating turns, and a four-direction
// win scan (one direction per clock) around the most recently placed cell.
`timescale 1ns/1ps
module connect_board_engine #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int WIN_LEN = 4,
  parameter int COL_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 drop_valid,
  input  logic [COL_W-1:0]     drop_col,
  output logic                 drop_ready,
  output logic                 drop_done,
  output logic                 drop_invalid,
  output logic [ROWS*COLS-1:0] occupied,
  output logic [ROWS*COLS-1:0] player_cells,
  output logic                 cur_player,
  output logic [1:0]           game_status,
  output logic [7:0]           led
);
  localparam int N  = ROWS * COLS;
  localparam int HW = $clog2(ROWS + 1);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {IDLE, PLACE, CHK0, CHK1, CHK2, CHK3, RESULT} state_t;
  state_t state, state_next;

  // Sized to the full column-index range so out-of-range columns still index safely.
  logic [HW-1:0]    height [2**COL_W];
  logic [COL_W-1:0] place_col;
  logic [HW-1:0]    place_row;
  logic             win;
  logic             accept, drop_bad, line_hit;
  logic [IW-1:0]    wr_idx;
  int               dr, dc, r, c, idx, line;
  logic             run;

  assign accept   = drop_valid && drop_ready;
  assign drop_bad = ({1'b0, drop_col} >= (COL_W+1)'(COLS)) || (height[drop_col] == HW'(ROWS));
  assign wr_idx   = IW'(int'(place_row) * COLS + int'(place_col));

  // Walk outward on both sides of the placed cell; each side stops at the
  // first edge, empty cell or opponent piece.
  always_comb begin
    dr   = 0;
    dc   = 0;
    r    = 0;
    c    = 0;
    idx  = 0;
    line = 1;
    run  = 1'b0;
    case (state)
      CHK0:    begin dr = 0;  dc = 1; end
      CHK1:    begin dr = 1;  dc = 0; end
      CHK2:    begin dr = 1;  dc = 1; end
      CHK3:    begin dr = -1; dc = 1; end
      default: begin dr = 0;  dc = 0; end
    endcase
    for (int s = -1; s <= 1; s += 2) begin
      run = 1'b1;
      for (int k = 1; k < WIN_LEN; k++) begin
        r = int'(place_row) + s * k * dr;
        c = int'(place_col) + s * k * dc;
        if (run && r >= 0 && r < ROWS && c >= 0 && c < COLS) begin
          idx = r * COLS + c;
          if (occupied[IW'(idx)] && (player_cells[IW'(idx)] == cur_player)) line = line + 1;
          else run = 1'b0;
        end else begin
          run = 1'b0;
        end
      end
    end
    line_hit = (line >= WIN_LEN);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !drop_bad) state_next = PLACE;
      PLACE:   state_next = CHK0;
      CHK0:    state_next = CHK1;
      CHK1:    state_next = CHK2;
      CHK2:    state_next = CHK3;
      CHK3:    state_next = RESULT;
      RESULT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    drop_ready = (state == IDLE) && (game_status == 2'b00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occupied     <= '0;
      player_cells <= '0;
      cur_player   <= 1'b0;
      game_status  <= 2'b00;
      drop_done    <= 1'b0;
      drop_invalid <= 1'b0;
      led          <= '0;
      win          <= 1'b0;
      place_col    <= '0;
      place_row    <= '0;
      for (int i = 0; i < 2**COL_W; i++) height[i] <= '0;
    end else begin
      drop_done    <= 1'b0;
      drop_invalid <= 1'b0;
      led          <= 8'(occupied);
      case (state)
        IDLE: begin
          if (accept) begin
            if (drop_bad) begin
              drop_invalid <= 1'b1;
            end else begin
              place_col <= drop_col;
              place_row <= height[drop_col];
              win       <= 1'b0;
            end
          end
        end
        PLACE: begin
          occupied[wr_idx]     <= 1'b1;
          player_cells[wr_idx] <= cur_player;
          height[place_col]    <= height[place_col] + HW'(1);
        end
        CHK0, CHK1, CHK2, CHK3: begin
          if (line_hit) win <= 1'b1;
        end
        RESULT: begin
          drop_done <= 1'b1;
          if (win)            game_status <= cur_player ? 2'b10 : 2'b01;
          else if (&occupied) game_status <= 2'b11;
          else                cur_player  <= ~cur_player;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_connect_board_engine.sv
// Directed bench for connect_board_engine: three board geometries, expected
// drop outcomes queued at issue time and checked when the pulse appears.
`timescale 1ns/1ps
module tb_connect_board_engine;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        dv   [3];
  logic [1:0]  dcol [3];
  logic        rdy  [3];
  logic        done [3];
  logic        inv  [3];
  logic        cp   [3];
  logic [1:0]  st   [3];
  logic [7:0]  led  [3];
  logic [15:0] occ  [3];
  logic [15:0] pc   [3];

  logic [15:0] occ0, pc0;
  logic [11:0] occ1, pc1;
  logic [3:0]  occ2, pc2;

  assign occ[0] = occ0;
  assign pc[0]  = pc0;
  assign occ[1] = {4'b0, occ1};
  assign pc[1]  = {4'b0, pc1};
  assign occ[2] = {12'b0, occ2};
  assign pc[2]  = {12'b0, pc2};

  connect_board_engine #(.ROWS(4), .COLS(4), .WIN_LEN(4), .COL_W(2)) u_dut0 (
    .clk(clk), .reset(reset), .drop_valid(dv[0]), .drop_col(dcol[0]),
    .drop_ready(rdy[0]), .drop_done(done[0]), .drop_invalid(inv[0]),
    .occupied(occ0), .player_cells(pc0), .cur_player(cp[0]),
    .game_status(st[0]), .led(led[0]));

  connect_board_engine #(.ROWS(4), .COLS(3), .WIN_LEN(4), .COL_W(2)) u_dut1 (
    .clk(clk), .reset(reset), .drop_valid(dv[1]), .drop_col(dcol[1]),
    .drop_ready(rdy[1]), .drop_done(done[1]), .drop_invalid(inv[1]),
    .occupied(occ1), .player_cells(pc1), .cur_player(cp[1]),
    .game_status(st[1]), .led(led[1]));

  connect_board_engine #(.ROWS(2), .COLS(2), .WIN_LEN(3), .COL_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .drop_valid(dv[2]), .drop_col(dcol[2]),
    .drop_ready(rdy[2]), .drop_done(done[2]), .drop_invalid(inv[2]),
    .occupied(occ2), .player_cells(pc2), .cur_player(cp[2]),
    .game_status(st[2]), .led(led[2]));

  typedef struct {
    int         sel;
    bit         inv;
    logic [1:0] st;
    logic       cp;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one drop, wait (bounded) for its done/invalid pulse, then score it.
  task automatic drop(input int sel, input logic [1:0] col, input bit exp_inv,
                      input logic [1:0] exp_st, input logic exp_cp);
    exp_t e;
    int   n;
    exp_q.push_back('{sel, exp_inv, exp_st, exp_cp});
    @(negedge clk);
    dv[sel]   = 1'b1;
    dcol[sel] = col;
    @(posedge clk);
    #1;
    dv[sel] = 1'b0;
    n = 1;
    while (!(done[sel] || inv[sel]) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = exp_q.pop_front();
    check($sformatf("pulse d%0d c%0d", e.sel, col), {30'b0, done[sel], inv[sel]},
          e.inv ? 32'd1 : 32'd2);
    check($sformatf("latency d%0d c%0d", e.sel, col), n, e.inv ? 1 : 7);
    check($sformatf("status d%0d c%0d", e.sel, col), {30'b0, st[sel]}, {30'b0, e.st});
    check($sformatf("turn d%0d c%0d", e.sel, col), {31'b0, cp[sel]}, {31'b0, e.cp});
    @(posedge clk);
    #1;
    check($sformatf("pulse_clear d%0d", e.sel), {30'b0, done[sel], inv[sel]}, 0);
  endtask

  // A request after the game is decided must produce no pulse at all.
  task automatic ignored_drop(input int sel, input logic [1:0] col);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    dv[sel]   = 1'b1;
    dcol[sel] = col;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      dv[sel] = 1'b0;
      seen = seen | done[sel] | inv[sel];
    end
    check($sformatf("ignored_pulse d%0d", sel), {31'b0, seen}, 0);
    check($sformatf("ignored_ready d%0d", sel), {31'b0, rdy[sel]}, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      dv[i]   = 1'b0;
      dcol[i] = 2'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_occ",    occ[0], 0);
    check("rst_pc",     pc[0], 0);
    check("rst_turn",   {31'b0, cp[0]}, 0);
    check("rst_status", {30'b0, st[0]}, 0);
    check("rst_ready",  {31'b0, rdy[0]}, 1);
    check("rst_led",    {24'b0, led[0]}, 0);
    check("rst_pulses", {30'b0, done[0], inv[0]}, 0);

    // Vertical win for P0
    drop(0, 2'd0, 0, 2'b00, 1'b1);
    drop(0, 2'd1, 0, 2'b00, 1'b0);
    drop(0, 2'd0, 0, 2'b00, 1'b1);
    drop(0, 2'd1, 0, 2'b00, 1'b0);
    drop(0, 2'd0, 0, 2'b00, 1'b1);
    drop(0, 2'd1, 0, 2'b00, 1'b0);
    drop(0, 2'd0, 0, 2'b01, 1'b0);
    check("vert_occ",   occ[0], 16'h1333);
    check("vert_pc",    pc[0], 16'h0222);
    check("vert_ready", {31'b0, rdy[0]}, 0);
    check("vert_led",   {24'b0, led[0]}, 32'h33);
    ignored_drop(0, 2'd2);
    check("vert_occ_after", occ[0], 16'h1333);

    // Full column
    do_reset();
    drop(0, 2'd0, 0, 2'b00, 1'b1);
    drop(0, 2'd0, 0, 2'b00, 1'b0);
    drop(0, 2'd0, 0, 2'b00, 1'b1);
    drop(0, 2'd0, 0, 2'b00, 1'b0);
    drop(0, 2'd0, 1, 2'b00, 1'b0);
    check("full_occ",   occ[0], 16'h1111);
    check("full_pc",    pc[0], 16'h1010);
    check("full_ready", {31'b0, rdy[0]}, 1);

    // Diagonal "/" win for P0
    do_reset();
    drop(0, 2'd0, 0, 2'b00, 1'b1);
    drop(0, 2'd1, 0, 2'b00, 1'b0);
    drop(0, 2'd1, 0, 2'b00, 1'b1);
    drop(0, 2'd2, 0, 2'b00, 1'b0);
    drop(0, 2'd2, 0, 2'b00, 1'b1);
    drop(0, 2'd3, 0, 2'b00, 1'b0);
    drop(0, 2'd2, 0, 2'b00, 1'b1);
    drop(0, 2'd3, 0, 2'b00, 1'b0);
    drop(0, 2'd3, 0, 2'b00, 1'b1);
    drop(0, 2'd0, 0, 2'b00, 1'b0);
    drop(0, 2'd3, 0, 2'b01, 1'b0);
    check("diag_occ", occ[0], 16'h8CFF);
    check("diag_pc",  pc[0], 16'h009E);
    check("diag_led", {24'b0, led[0]}, 32'hFF);
    ignored_drop(0, 2'd1);
    ignored_drop(0, 2'd0);
    check("diag_status_after", {30'b0, st[0]}, 32'h1);

    // Reset during the diagonal "/" scan
    do_reset();
    @(negedge clk);
    dv[0]   = 1'b1;
    dcol[0] = 2'd1;
    @(posedge clk);
    #1;
    dv[0] = 1'b0;
    @(posedge clk);
    #1;
    check("mid_board_visible", occ[0], 16'h0002);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_occ",    occ[0], 0);
    check("mid_pc",     pc[0], 0);
    check("mid_turn",   {31'b0, cp[0]}, 0);
    check("mid_status", {30'b0, st[0]}, 0);
    check("mid_ready",  {31'b0, rdy[0]}, 1);
    check("mid_pulses", {30'b0, done[0], inv[0]}, 0);
    drop(0, 2'd0, 0, 2'b00, 1'b1);
    check("mid_next_occ", occ[0], 16'h0001);

    // Out-of-range column on a 3-column board
    drop(1, 2'd3, 1, 2'b00, 1'b0);
    check("oor_occ",   occ[1], 0);
    check("oor_ready", {31'b0, rdy[1]}, 1);
    drop(1, 2'd2, 0, 2'b00, 1'b1);
    check("oor_next_occ", occ[1], 16'h0004);

    // Draw on a 2x2 board needing three in a line
    drop(2, 2'd0, 0, 2'b00, 1'b1);
    drop(2, 2'd1, 0, 2'b00, 1'b0);
    drop(2, 2'd0, 0, 2'b00, 1'b1);
    drop(2, 2'd1, 0, 2'b11, 1'b1);
    check("draw_occ",   occ[2], 16'h000F);
    check("draw_pc",    pc[2], 16'h000A);
    check("draw_ready", {31'b0, rdy[2]}, 0);
    check("draw_led",   {24'b0, led[2]}, 32'h0F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
